pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard, bypass and stall controller for the in-order pipelines in this design. It tracks in-flight register writes through a configurable number of post-decode stages and produces per-operand forwarding selects, a decode stall for load-use hazards, and bubble insertion. It accepts a freeze request from multicycle units and a flush request from branch/jump resolution. It sits beside the decode stage, and its outputs drive the stage-latch write enables and the operand bypass muxes.

## Interface
Parameters:
- REG_AW, 5: register-address width; register 0 is hardwired zero and never matches.
- DEPTH, 3: tracked stages after decode; entry 1 = E, entry DEPTH = W. Must be ≥ 2.
- LOAD_STAGE, 2: first entry index at which a load result can be forwarded. Range 1..DEPTH.
- SELW, $clog2(DEPTH+1): select width (derived; not overridden).

Ports:
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-low.
- d_valid, in, 1: decode holds a real instruction.
- d_rs_a / d_rs_b, in, REG_AW: source registers.
- d_use_a / d_use_b, in, 1: the source is actually read.
- d_rd, in, REG_AW: destination register.
- d_wr, in, 1: the instruction writes d_rd.
- d_load, in, 1: the instruction is a load.
- freeze, in, 1: multicycle unit busy; hold the whole pipeline.
- flush, in, 1: branch/jump taken in E; discard the decode instruction.
- stall_o, out, 1: hold PC and the F/D latch.
- bubble_o, out, 1: write a no-op into the D/E latch.
- fwd_a_sel / fwd_b_sel, out, SELW: 0 = regfile; k = value from entry k.
- stage_valid, out, DEPTH: valid bit per entry, bit k-1 = entry k.
- stall_cnt, out, 32: present only with HAZ_PERF_CNT_EN.

## Operation
- State: DEPTH entries of {valid, rd, wr, load}.
- Advance (freeze=0):
  - entry k+1 ← entry k.
  - entry 1 ← decode fields with valid = d_valid & ~stall_o & ~flush.
- Freeze (freeze=1): all entries hold. stall_o=1. bubble_o=0.
- Match: entry k matches source s when:
  - valid & wr,
  - rd == s,
  - s != 0,
  - use_s = 1.
- Selection: the youngest (lowest k) match wins. fwd_*_sel = k, or 0 if there is no match.
- Load-use hazard: the winning match has load=1 and k < LOAD_STAGE. An older match never masks it.
  - Result: stall_o=1, bubble_o=1.
  - fwd sel is still driven with the winning k; downstream ignores it while stalled.
- Flush: bubble_o=1 and stall_o=0. This holds even when a hazard exists, because the decode instruction is discarded.
- Priority: reset > freeze > flush > hazard stall.
  - flush is ignored during freeze; the source must hold flush until freeze drops.
- Without d_valid: no hazard, stall_o=0, and entry 1 gets a bubble.

## Timing
- stall_o, bubble_o and fwd sels are combinational from the registered entries plus decode inputs in the same cycle. There are no registered outputs except stall_cnt and stage_valid.
- Load-use with LOAD_STAGE=2: exactly one stall cycle. The next cycle selects 2.
- Load-use with general LOAD_STAGE=L: L-1 stall cycles.
- A written entry is visible to matching in the cycle after the edge that wrote it. Writeback-to-decode same-cycle forwarding uses sel = DEPTH.
- Reset low at an edge: all valid ← 0 and stall_cnt ← 0.
- While reset is low, all outputs are forced to 0.
- Reset mid-stall: the stall releases on the next cycle, and in-flight entries are discarded.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cnt increments by 1 on every edge where stall_o=1 and reset is high, freeze cycles included.
  - Wraps 0xFFFFFFFF → 0.
- HAZ_PERF_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Back-to-back ALU: `add r3` then `sub r4,r3,r5` with DEPTH=3 → fwd_a_sel=1, fwd_b_sel=0, stall_o=0.
- Load-use: `lw r7` then `add r8,r7,r7` with LOAD_STAGE=2 → cycle 1: stall_o=1, bubble_o=1; cycle 2: stall_o=0, fwd_a_sel=fwd_b_sel=2; stall_cnt=1.
- Youngest wins, and r0 is never forwarded:
  - writes to r2 in entries 3 and 1 → sel=1.
  - d_rs_a=0 while entry 1 has rd=0 with wr set → sel=0.
- Flush plus hazard: load-use pending and flush=1 in the same cycle → stall_o=0, bubble_o=1; next cycle stage_valid[0]=0.
- Freeze: 4 cycles with freeze=1 → stage_valid is unchanged, stall_o=1, stall_cnt +4. After release, entries shift once per cycle.
- Reset mid-operation: reset=0 for one edge with all entries valid → stage_valid=0, outputs 0, stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, bypass and stall controller tracking in-flight register writes behind decode.
// Optional stall performance counter (stall_cnt port) is built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs_a,
    input  logic [REG_AW-1:0] d_rs_b,
    input  logic              d_use_a,
    input  logic              d_use_b,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_wr,
    input  logic              d_load,
    input  logic              freeze,
    input  logic              flush,
    output logic              stall_o,
    output logic              bubble_o,
    output logic [SELW-1:0]   fwd_a_sel,
    output logic [SELW-1:0]   fwd_b_sel,
    output logic [DEPTH-1:0]  stage_valid
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  wr_r;
    logic [DEPTH-1:0]  load_r;
    logic [REG_AW-1:0] rd_r [DEPTH];

    logic [SELW-1:0]   sel_a_s;
    logic [SELW-1:0]   sel_b_s;
    logic              haz_a_s;
    logic              haz_b_s;
    logic              stall_s;
    logic              bubble_s;
    logic              ent_valid_s;

    // Register 0 is hardwired zero, so it can never be a forwarding source.
    function automatic logic src_match(input logic v, input logic w, input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] src, input logic use_src);
        return v && w && use_src && (src != {REG_AW{1'b0}}) && (rd == src);
    endfunction

    // Scan oldest to youngest so the youngest matching entry overwrites the selection.
    always_comb begin
        sel_a_s = {SELW{1'b0}};
        sel_b_s = {SELW{1'b0}};
        haz_a_s = 1'b0;
        haz_b_s = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (src_match(valid_r[k-1], wr_r[k-1], rd_r[k-1], d_rs_a, d_use_a)) begin
                sel_a_s = SELW'(k);
                haz_a_s = load_r[k-1] && (k < LOAD_STAGE);
            end else begin
                sel_a_s = sel_a_s;
            end
            if (src_match(valid_r[k-1], wr_r[k-1], rd_r[k-1], d_rs_b, d_use_b)) begin
                sel_b_s = SELW'(k);
                haz_b_s = load_r[k-1] && (k < LOAD_STAGE);
            end else begin
                sel_b_s = sel_b_s;
            end
        end
    end

    // Stall/bubble priority: reset, then freeze, then flush, then load-use hazard.
    always_comb begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        if (!reset) begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
        end else if (freeze) begin
            stall_s  = 1'b1;
            bubble_s = 1'b0;
        end else if (flush) begin
            stall_s  = 1'b0;
            bubble_s = 1'b1;
        end else if (d_valid && (haz_a_s || haz_b_s)) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
        end else begin
            stall_s  = 1'b0;
            bubble_s = 1'b0;
        end
    end

    assign ent_valid_s = d_valid && !stall_s && !flush;

    assign stall_o     = stall_s;
    assign bubble_o    = bubble_s;
    assign fwd_a_sel   = reset ? sel_a_s : {SELW{1'b0}};
    assign fwd_b_sel   = reset ? sel_b_s : {SELW{1'b0}};
    assign stage_valid = reset ? valid_r : {DEPTH{1'b0}};

    // Entry shift register: decode enters entry 1, everything moves one stage unless frozen.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_r <= {DEPTH{1'b0}};
            wr_r    <= {DEPTH{1'b0}};
            load_r  <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                rd_r[k] <= {REG_AW{1'b0}};
            end
        end else if (!freeze) begin
            valid_r <= {valid_r[DEPTH-2:0], ent_valid_s};
            wr_r    <= {wr_r[DEPTH-2:0], d_wr};
            load_r  <= {load_r[DEPTH-2:0], d_load};
            rd_r[0] <= d_rd;
            for (int k = 1; k < DEPTH; k++) begin
                rd_r[k] <= rd_r[k-1];
            end
        end else begin
            valid_r <= valid_r;
            wr_r    <= wr_r;
            load_r  <= load_r;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Counts every stalled edge, freeze cycles included; wraps naturally at 32 bits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = reset ? stall_cnt_r : 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a queue-based pipeline model predicts each cycle's outputs.
// Directed scenarios cover the key hazard cases, then randomized traffic runs against the model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW     = 5;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 2;
    localparam int SELW       = 2;

    logic              clock;
    logic              reset;
    logic              d_valid;
    logic [REG_AW-1:0] d_rs_a;
    logic [REG_AW-1:0] d_rs_b;
    logic              d_use_a;
    logic              d_use_b;
    logic [REG_AW-1:0] d_rd;
    logic              d_wr;
    logic              d_load;
    logic              freeze;
    logic              flush;
    logic              stall_o;
    logic              bubble_o;
    logic [SELW-1:0]   fwd_a_sel;
    logic [SELW-1:0]   fwd_b_sel;
    logic [DEPTH-1:0]  stage_valid;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)
    ) dut (
        .clock(clock), .reset(reset), .d_valid(d_valid),
        .d_rs_a(d_rs_a), .d_rs_b(d_rs_b), .d_use_a(d_use_a), .d_use_b(d_use_b),
        .d_rd(d_rd), .d_wr(d_wr), .d_load(d_load), .freeze(freeze), .flush(flush),
        .stall_o(stall_o), .bubble_o(bubble_o), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stage_valid(stage_valid)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
    } ent_t;

    typedef struct {
        logic             stall;
        logic             bubble;
        logic [SELW-1:0]  sel_a;
        logic [SELW-1:0]  sel_b;
        logic [DEPTH-1:0] sv;
        logic [31:0]      cnt;
    } exp_t;

    ent_t        pipe[$];   // index 0 = entry 1 (youngest)
    exp_t        scb[$];
    exp_t        cur_exp;
    logic [31:0] m_cnt;
    int          checks;
    int          failures;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // First (youngest) entry writing a nonzero source register that is actually read.
    function automatic int find_src(input logic [REG_AW-1:0] src, input logic use_src);
        if (!use_src || src == 5'd0) return 0;
        for (int i = 0; i < pipe.size(); i++) begin
            if (pipe[i].valid && pipe[i].wr && pipe[i].rd == src) return i + 1;
        end
        return 0;
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        int   ka;
        int   kb;
        logic haz;
        e.stall = 1'b0; e.bubble = 1'b0; e.sel_a = 2'd0; e.sel_b = 2'd0;
        e.sv = 3'd0; e.cnt = 32'd0;
        if (!reset) return e;
        ka = find_src(d_rs_a, d_use_a);
        kb = find_src(d_rs_b, d_use_b);
        haz = d_valid && (((ka != 0) && pipe[ka-1].load && (ka < LOAD_STAGE)) ||
                          ((kb != 0) && pipe[kb-1].load && (kb < LOAD_STAGE)));
        e.sel_a = SELW'(ka);
        e.sel_b = SELW'(kb);
        if (freeze) begin
            e.stall = 1'b1;
        end else if (flush) begin
            e.bubble = 1'b1;
        end else if (haz) begin
            e.stall = 1'b1; e.bubble = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) e.sv[i] = pipe[i].valid;
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic model_edge();
        ent_t n;
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i].valid = 1'b0;
            m_cnt = 32'd0;
        end else begin
            if (cur_exp.stall) m_cnt = m_cnt + 32'd1;
            if (!freeze) begin
                n.valid = d_valid && !cur_exp.stall && !flush;
                n.rd = d_rd; n.wr = d_wr; n.load = d_load;
                pipe.push_front(n);
                void'(pipe.pop_back());
            end
        end
    endtask

    task automatic tick(input logic rst, input logic dv, input logic [4:0] ra, input logic ua,
                        input logic [4:0] rb, input logic ub, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic frz, input logic fl);
        @(posedge clock);
        model_edge();
        #1;
        reset = rst; d_valid = dv; d_rs_a = ra; d_use_a = ua; d_rs_b = rb; d_use_b = ub;
        d_rd = rd; d_wr = wr; d_load = ld; freeze = frz; flush = fl;
        cur_exp = model_eval();
        scb.push_back(cur_exp);
    endtask

    // Monitor: compares every presented cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (scb.size() > 0) begin
                e = scb.pop_front();
                chk("sb_stall", 32'(stall_o), 32'(e.stall));
                chk("sb_bubble", 32'(bubble_o), 32'(e.bubble));
                chk("sb_sel_a", 32'(fwd_a_sel), 32'(e.sel_a));
                chk("sb_sel_b", 32'(fwd_b_sel), 32'(e.sel_b));
                chk("sb_stage_valid", 32'(stage_valid), 32'(e.sv));
`ifdef HAZ_PERF_CNT_EN
                chk("sb_stall_cnt", stall_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin
        ent_t z;
        checks = 0; failures = 0; m_cnt = 32'd0;
        z.valid = 1'b0; z.rd = 5'd0; z.wr = 1'b0; z.load = 1'b0;
        for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
        cur_exp = '{1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 32'd0};
        reset = 1'b0; d_valid = 1'b0; d_rs_a = 5'd0; d_rs_b = 5'd0; d_use_a = 1'b0;
        d_use_b = 1'b0; d_rd = 5'd0; d_wr = 1'b0; d_load = 1'b0; freeze = 1'b0; flush = 1'b0;

        // Reset state
        tick(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("rst_stage_valid", 32'(stage_valid), 32'd0);

        // Back-to-back ALU: add r3 ; sub r4,r3,r5
        tick(1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("b2b_sel_a", 32'(fwd_a_sel), 32'd1);
        chk("b2b_sel_b", 32'(fwd_b_sel), 32'd0);
        chk("b2b_stall", 32'(stall_o), 32'd0);

        // Load-use: lw r7 ; add r8,r7,r7 -> one stall cycle then forward from entry 2
        tick(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("lu_stall_c1", 32'(stall_o), 32'd1);
        chk("lu_bubble_c1", 32'(bubble_o), 32'd1);
        tick(1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("lu_stall_c2", 32'(stall_o), 32'd0);
        chk("lu_sel_a_c2", 32'(fwd_a_sel), 32'd2);
        chk("lu_sel_b_c2", 32'(fwd_b_sel), 32'd2);

        // Youngest wins: r2 written in entries 3 and 1
        tick(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("young_sel_a", 32'(fwd_a_sel), 32'd1);
        // r0 is never forwarded
        tick(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("r0_sel_a", 32'(fwd_a_sel), 32'd0);

        // Flush overrides a pending load-use hazard
        tick(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        chk("fl_stall", 32'(stall_o), 32'd0);
        chk("fl_bubble", 32'(bubble_o), 32'd1);
        tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("fl_entry1_valid", 32'(stage_valid[0]), 32'd0);

        // Freeze holds all entries for 4 cycles, then entries shift once per cycle
        for (int i = 0; i < 3; i++)
            tick(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(12 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0, 1'b1, 1'b1);
            @(negedge clock);
            chk("frz_stage_valid", 32'(stage_valid), 32'd7);
            chk("frz_stall", 32'(stall_o), 32'd1);
            chk("frz_bubble", 32'(bubble_o), 32'd0);
        end
        tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("frz_rel_shift1", 32'(stage_valid), 32'd6);
        tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("frz_rel_shift2", 32'(stage_valid), 32'd4);

        // Reset mid-operation with all entries valid and a hazard pending
        for (int i = 0; i < 3; i++)
            tick(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(12 + i), 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 5'd14, 1'b1, 5'd13, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("rst_mid_stall", 32'(stall_o), 32'd0);
        chk("rst_mid_sel_a", 32'(fwd_a_sel), 32'd0);
        chk("rst_mid_stage_valid", 32'(stage_valid), 32'd0);
        tick(1'b1, 1'b1, 5'd14, 1'b1, 5'd13, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("rst_after_stall", 32'(stall_o), 32'd0);
        chk("rst_after_stage_valid", 32'(stage_valid), 32'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("rst_after_stall_cnt", stall_cnt, 32'd0);
`endif

        // Randomized traffic over a small register space so hazards are frequent
        for (int n = 0; n < 600; n++) begin
            tick(($urandom_range(39) != 0), ($urandom_range(5) != 0),
                 5'($urandom_range(3)), 1'($urandom_range(1)),
                 5'($urandom_range(3)), 1'($urandom_range(1)),
                 5'($urandom_range(3)), ($urandom_range(3) != 0), ($urandom_range(2) == 0),
                 ($urandom_range(7) == 0), ($urandom_range(7) == 0));
        end

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
